mac_acc_unit: RTL and testbench

- Parametrised multi-channel fixed-point multiply-accumulate unit. It is the next generation of the CPU's single-accumulator ALU datapath (acc add, MACI multiply-accumulate).
- Adds NACC independent accumulators, a 2-stage pipeline with valid/ready input handshake, selectable saturation, a sticky overflow flag and a multi-cycle clear-all sweep.
- Sits between the CPU decoder and the register file / LED output path.

---
 rtl/mac_acc_unit.sv | 177 +++++++++++++++++
 tb/tb_mac_acc_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_unit.sv
// Multi-channel fixed-point multiply-accumulate unit: 2-stage pipeline,
// NACC accumulators, optional saturation, sticky overflow and clear-all sweep.
module mac_acc_unit #(
    parameter int N    = 8,
    parameter int FRAC = 7,
    parameter int NACC = 4,
    parameter int SAT  = 1,
    localparam int CW  = (NACC > 1) ? $clog2(NACC) : 1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    op,
    input  logic [CW-1:0] ch,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [N-1:0]  out_data,
    output logic          ovf,
    input  logic          ovf_clr
);

    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_MAC, OP_CLRALL} op_e;
    typedef enum logic {ST_RUN, ST_SWEEP} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic                 s1_valid_q, s1_valid_d;
    op_e                  s1_op_q, s1_op_d;
    logic [CW-1:0]        s1_ch_q, s1_ch_d;
    logic signed [N-1:0]  s1_a_q, s1_a_d;
    logic signed [N-1:0]  s1_b_q, s1_b_d;
    logic [N-1:0]         acc_q [NACC];
    logic [N-1:0]         acc_d [NACC];
    logic                 out_valid_q, out_valid_d;
    logic [CW-1:0]        out_ch_q, out_ch_d;
    logic [N-1:0]         out_data_q, out_data_d;
    logic                 ovf_q, ovf_d;

    logic                 accept;
    logic                 ch_ok;
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] prod_sh;
    logic signed [2*N:0]   term;
    logic signed [2*N:0]   acc_ext;
    logic signed [2*N:0]   sum;
    logic                  sum_ovf;
    logic [N-1:0]          sum_res;

    // A CLRALL sitting in stage 1 already blocks new ops, before the sweep starts.
    assign in_ready = (state_q == ST_RUN) && !(s1_valid_q && (s1_op_q == OP_CLRALL));
    assign accept   = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q;

    // Stage 2 datapath: everything widened to 2N+1 bits so the sum cannot wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ch_ok   = (32'(s1_ch_q) < NACC);
        prod    = s1_a_q * s1_b_q;
        prod_sh = prod >>> FRAC;
        acc_ext = '0;
        if (ch_ok) begin
            acc_ext = {{(N+1){acc_q[s1_ch_q][N-1]}}, acc_q[s1_ch_q]};
        end
        if (s1_op_q == OP_MAC) begin
            term = {prod_sh[2*N-1], prod_sh};
        end else begin
            term = {{(N+1){s1_a_q[N-1]}}, s1_a_q};
        end
        sum     = (s1_op_q == OP_LOAD) ? term : (acc_ext + term);
        sum_ovf = !((&sum[2*N:N-1]) || !(|sum[2*N:N-1]));
        if ((SAT != 0) && sum_ovf) begin
            sum_res = sum[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            sum_res = sum[N-1:0];
        end
    end

    always_comb begin
        s1_valid_d  = accept;
        s1_op_d     = s1_op_q;
        s1_ch_d     = s1_ch_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        if (accept) begin
            s1_op_d = op_e'(op);
            s1_ch_d = ch;
            s1_a_d  = a;
            s1_b_d  = b;
        end

        acc_d       = acc_q;
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        case (state_q)
            ST_RUN: begin
                if (s1_valid_q) begin
                    if (s1_op_q == OP_CLRALL) begin
                        acc_d[0] = '0;
                        ovf_d    = 1'b0;
                        if (NACC > 1) begin
                            state_d = ST_SWEEP;
                            idx_d   = CW'(1);
                        end
                    end else if (ch_ok) begin
                        acc_d[s1_ch_q] = sum_res;
                        out_valid_d    = 1'b1;
                        out_ch_d       = s1_ch_q;
                        out_data_d     = sum_res;
                        // Setting beats a simultaneous ovf_clr.
                        if (sum_ovf) begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            ST_SWEEP: begin
                acc_d[idx_q] = '0;
                idx_d        = idx_q + CW'(1);
                if (32'(idx_q) == NACC - 1) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_LOAD;
            s1_ch_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            // NOTE: the accumulator bank is reset because software relies on all channels starting at 0.
            for (int i = 0; i < NACC; i++) begin
                acc_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_ch_q     <= s1_ch_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_acc_unit.sv
// Directed bench for mac_acc_unit: a saturating and a wrapping instance share
// one stimulus stream; expected values are hand-computed for N=8, FRAC=7, NACC=4.
module tb_mac_acc_unit;

    localparam logic [1:0] OP_LOAD = 2'd0, OP_ADD = 2'd1, OP_MAC = 2'd2, OP_CLRALL = 2'd3;

    logic       clk, n_reset, in_valid, ovf_clr;
    logic [1:0] op, ch;
    logic [7:0] a, b;
    logic       in_ready, out_valid_s, ovf_s;
    logic [1:0] out_ch_s;
    logic [7:0] out_data_s;
    logic       in_ready_w, out_valid_w, ovf_w;
    logic [1:0] out_ch_w;
    logic [7:0] out_data_w;

    int checks = 0;
    int errors = 0;

    mac_acc_unit #(.N(8), .FRAC(7), .NACC(4), .SAT(1)) dut_sat (
        .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ch(ch), .a(a), .b(b), .out_valid(out_valid_s), .out_ch(out_ch_s),
        .out_data(out_data_s), .ovf(ovf_s), .ovf_clr(ovf_clr)
    );

    mac_acc_unit #(.N(8), .FRAC(7), .NACC(4), .SAT(0)) dut_wrap (
        .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .op(op), .ch(ch), .a(a), .b(b), .out_valid(out_valid_w), .out_ch(out_ch_w),
        .out_data(out_data_w), .ovf(ovf_w), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [1:0] c, input logic [7:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        op = o;
        ch = c;
        a = av;
        b = bv;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        idle();
        ovf_clr = 1'b0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_s); end
        checks++; if ({ovf_s, ovf_w} !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b expected 00", {ovf_s, ovf_w}); end
        checks++; if ({out_ch_s, out_data_s} !== 10'd0) begin errors++; $display("FAIL reset_out: got ch %0d data %0d expected 0 0", out_ch_s, out_data_s); end
        @(negedge clk);
        n_reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(OP_ADD, 2'(c), 8'd0, 8'd0); else idle();
            tick();
            if (c > 0) begin
                checks++;
                if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'(c - 1), 8'd0}) begin
                    errors++; $display("FAIL reset_acc_zero: ch %0d got valid %b data %0d expected valid 1 data 0", c - 1, out_valid_s, $signed(out_data_s));
                end
            end
        end
    endtask

    task automatic test_load_add();
        drive(OP_LOAD, 2'd0, 8'd45, 8'd0);
        tick();
        drive(OP_ADD, 2'd0, 8'hC7, 8'd0);
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd0, 8'd45}) begin errors++; $display("FAIL load_result: got valid %b ch %0d data %0d expected 1 0 45", out_valid_s, out_ch_s, $signed(out_data_s)); end
        idle();
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd0, 8'hF4}) begin errors++; $display("FAIL add_result: got valid %b ch %0d data %0d expected 1 0 -12", out_valid_s, out_ch_s, $signed(out_data_s)); end
        tick();
        checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL add_strobe_once: got out_valid %b expected 0", out_valid_s); end
    endtask

    task automatic test_mac();
        drive(OP_LOAD, 2'd1, 8'd2, 8'd0);
        tick();
        drive(OP_MAC, 2'd1, 8'd4, 8'h60);
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd1, 8'd2}) begin errors++; $display("FAIL mac_load: got valid %b ch %0d data %0d expected 1 1 2", out_valid_s, out_ch_s, $signed(out_data_s)); end
        drive(OP_MAC, 2'd1, 8'd28, 8'hE0);
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd1, 8'd5}) begin errors++; $display("FAIL mac_pos: got valid %b ch %0d data %0d expected 1 1 5", out_valid_s, out_ch_s, $signed(out_data_s)); end
        drive(OP_ADD, 2'd0, 8'd0, 8'd0);
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd1, 8'hFE}) begin errors++; $display("FAIL mac_neg: got valid %b ch %0d data %0d expected 1 1 -2", out_valid_s, out_ch_s, $signed(out_data_s)); end
        idle();
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd0, 8'hF4}) begin errors++; $display("FAIL ch_independent: got valid %b ch %0d data %0d expected 1 0 -12", out_valid_s, out_ch_s, $signed(out_data_s)); end
    endtask

    task automatic test_overflow();
        drive(OP_LOAD, 2'd2, 8'd100, 8'd0);
        tick();
        drive(OP_ADD, 2'd2, 8'd100, 8'd0);
        tick();
        checks++; if (out_data_s !== 8'd100) begin errors++; $display("FAIL ovf_load: got %0d expected 100", $signed(out_data_s)); end
        idle();
        tick();
        checks++; if ({out_data_s, ovf_s} !== {8'd127, 1'b1}) begin errors++; $display("FAIL sat_add: got data %0d ovf %b expected 127 1", $signed(out_data_s), ovf_s); end
        checks++; if ({out_data_w, ovf_w} !== {8'hC8, 1'b1}) begin errors++; $display("FAIL wrap_add: got data %0d ovf %b expected -56 1", $signed(out_data_w), ovf_w); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if ({ovf_s, ovf_w} !== 2'b00) begin errors++; $display("FAIL ovf_clr: got %b expected 00", {ovf_s, ovf_w}); end
        drive(OP_LOAD, 2'd2, 8'd0, 8'd0);
        tick();
        drive(OP_MAC, 2'd2, 8'h80, 8'h80);
        tick();
        idle();
        tick();
        checks++; if ({out_data_s, ovf_s} !== {8'd127, 1'b1}) begin errors++; $display("FAIL sat_mac: got data %0d ovf %b expected 127 1", $signed(out_data_s), ovf_s); end
        checks++; if ({out_data_w, ovf_w} !== {8'h80, 1'b1}) begin errors++; $display("FAIL wrap_mac: got data %0d ovf %b expected -128 1", $signed(out_data_w), ovf_w); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        drive(OP_ADD, 2'd2, 8'd100, 8'd0);
        tick();
        idle();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if ({out_data_s, ovf_s} !== {8'd127, 1'b1}) begin errors++; $display("FAIL set_beats_clr: got data %0d ovf %b expected 127 1", $signed(out_data_s), ovf_s); end
        checks++; if ({out_data_w, ovf_w} !== {8'hE4, 1'b0}) begin errors++; $display("FAIL clr_no_ovf: got data %0d ovf %b expected -28 0", $signed(out_data_w), ovf_w); end
    endtask

    task automatic test_clrall();
        int low;
        drive(OP_LOAD, 2'd3, 8'd9, 8'd0);
        tick();
        drive(OP_CLRALL, 2'd0, 8'd0, 8'd0);
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd3, 8'd9}) begin errors++; $display("FAIL pre_clrall_op: got valid %b ch %0d data %0d expected 1 3 9", out_valid_s, out_ch_s, $signed(out_data_s)); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clrall_ready_drop: got %b expected 0", in_ready); end
        drive(OP_ADD, 2'd3, 8'd1, 8'd0);
        low = 1;
        for (int i = 0; i < 10 && in_ready !== 1'b1; i++) begin
            tick();
            checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL sweep_no_valid: got out_valid %b expected 0", out_valid_s); end
            if (in_ready !== 1'b1) low++;
        end
        checks++; if (low !== 4) begin errors++; $display("FAIL sweep_len: got %0d low cycles expected 4", low); end
        tick();
        idle();
        checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL held_add_latency: got out_valid %b expected 0", out_valid_s); end
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd3, 8'd1}) begin errors++; $display("FAIL post_clr_add: got valid %b ch %0d data %0d expected 1 3 1", out_valid_s, out_ch_s, $signed(out_data_s)); end
        checks++; if ({ovf_s, ovf_w} !== 2'b00) begin errors++; $display("FAIL clrall_ovf: got %b expected 00", {ovf_s, ovf_w}); end
        tick();
        checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL held_add_once: got out_valid %b expected 0", out_valid_s); end
        for (int c = 0; c < 4; c++) begin
            if (c < 3) drive(OP_ADD, 2'(c), 8'd0, 8'd0); else idle();
            tick();
            if (c > 0) begin
                checks++;
                if ({out_valid_s, out_data_s, out_data_w} !== {1'b1, 8'd0, 8'd0}) begin
                    errors++; $display("FAIL clrall_zero: ch %0d got valid %b data %0d/%0d expected 1 0/0", c - 1, out_valid_s, $signed(out_data_s), $signed(out_data_w));
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        drive(OP_LOAD, 2'd3, 8'd77, 8'd0);
        tick();
        drive(OP_CLRALL, 2'd0, 8'd0, 8'd0);
        tick();
        idle();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL in_sweep: got in_ready %b expected 0", in_ready); end
        #2;
        n_reset = 1'b0;
        #1;
        checks++; if ({in_ready, out_valid_s, out_ch_s, out_data_s, ovf_s} !== {1'b1, 1'b0, 2'd0, 8'd0, 1'b0}) begin
            errors++; $display("FAIL reset_mid_sweep: got ready %b valid %b ch %0d data %0d ovf %b expected 1 0 0 0 0", in_ready, out_valid_s, out_ch_s, $signed(out_data_s), ovf_s);
        end
        @(negedge clk);
        n_reset = 1'b1;
        drive(OP_ADD, 2'd3, 8'd0, 8'd0);
        tick();
        idle();
        tick();
        checks++; if ({out_valid_s, out_ch_s, out_data_s} !== {1'b1, 2'd3, 8'd0}) begin errors++; $display("FAIL reset_clears_acc: got valid %b ch %0d data %0d expected 1 3 0", out_valid_s, out_ch_s, $signed(out_data_s)); end
    endtask

    initial begin
        n_reset = 1'b0;
        in_valid = 1'b0;
        ovf_clr = 1'b0;
        op = OP_LOAD;
        ch = 2'd0;
        a = 8'd0;
        b = 8'd0;
        test_reset();
        test_load_add();
        test_mac();
        test_overflow();
        test_clrall();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
